// File: rtl/moving_avg_filter_if.sv
// Sample stream interface for one channel of the moving-average smoother.
// The master supplies noisy samples; the slave returns the filtered stream.
interface moving_avg_filter_if #(
  parameter int DATA_W = 24
);
  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     primed;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/moving_avg_filter.sv
// N-tap boxcar smoother: a running sum adds the newest sample and drops the
// oldest one from a circular history, and the output is sum >>> LOG2_N.
module moving_avg_filter #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  moving_avg_filter_if.slave bus
);
  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] FILL_FULL = (LOG2_N + 1)'(N);

  logic signed [DATA_W-1:0] hist_q [N];
  logic [N-1:0]             wr_en;
  logic [LOG2_N-1:0]        wptr_q, wptr_d;
  logic [LOG2_N:0]          fill_q, fill_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic signed [ACC_W-1:0]  new_ext, old_ext;
  logic signed [DATA_W-1:0] oldest;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     primed_q, primed_d;
  logic                     accept;

  assign accept  = bus.in_valid & ~bus.clear;
  assign oldest  = hist_q[wptr_q];
  assign new_ext = {{LOG2_N{bus.in_data[DATA_W-1]}}, bus.in_data};
  assign old_ext = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
  // ACC_W bits hold N full-scale samples, so this never wraps.
  assign acc_sum = acc_q + new_ext - old_ext;

  for (genvar gi = 0; gi < N; gi++) begin : g_wr_en
    assign wr_en[gi] = accept && (wptr_q == LOG2_N'(gi));
  end

  always_comb begin
    acc_d       = acc_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    primed_d    = primed_q;
    if (bus.clear) begin
      acc_d    = '0;
      wptr_d   = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (bus.in_valid) begin
      acc_d       = acc_sum;
      wptr_d      = wptr_q + 1'b1;
      fill_d      = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      // Dropping the low LOG2_N bits is an arithmetic shift, i.e. floor.
      out_data_d  = acc_sum[ACC_W-1:LOG2_N];
      out_valid_d = 1'b1;
      primed_d    = (fill_d == FILL_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.clear)    hist_q[i] <= '0;
        else if (wr_en[i]) hist_q[i] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: directed vector table, corner
// sequences and random traffic, all compared against a sliding-window model.
module tb_moving_avg_filter;
  localparam int DATA_W = 24;
  localparam int LOG2_N = 3;
  localparam int N      = 1 << LOG2_N;

  typedef struct {
    logic        v;
    logic        c;
    logic [23:0] d;
    logic        exp_v;
    logic [23:0] exp_d;
    logic        exp_p;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  moving_avg_filter_if #(.DATA_W(DATA_W)) bus ();

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          win[$];
  int          fill;
  logic        exp_v, exp_p;
  logic [23:0] exp_d;
  vec_t        tbl[$];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [23:0] floor_mean();
    longint s = 0;
    longint q;
    foreach (win[i]) s += win[i];
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q[23:0];
  endfunction

  task automatic model_reset();
    win = {};
    for (int i = 0; i < N; i++) win.push_back(0);
    fill  = 0;
    exp_v = 1'b0;
    exp_p = 1'b0;
    exp_d = '0;
  endtask

  // Drive one cycle of inputs at a falling edge, advance the model, and
  // compare the registered outputs at the following falling edge.
  task automatic tick(input logic v, input logic c, input logic [23:0] d, input string tag);
    logic signed [23:0] sd;
    bus.in_valid = v;
    bus.clear    = c;
    bus.in_data  = d;
    sd = d;
    if (c) begin
      foreach (win[i]) win[i] = 0;
      fill  = 0;
      exp_v = 1'b0;
      exp_p = 1'b0;
    end else if (v) begin
      void'(win.pop_front());
      win.push_back(int'(sd));
      if (fill < N) fill++;
      exp_d = floor_mean();
      exp_v = 1'b1;
      exp_p = (fill == N);
    end else begin
      exp_v = 1'b0;
    end
    @(negedge clk);
    $display("%s: v=%0b c=%0b d=%h -> out_valid=%0b out_data=%h primed=%0b",
             tag, v, c, d, bus.out_valid, bus.out_data, bus.primed);
    check({tag, " out_valid"}, 24'(bus.out_valid), 24'(exp_v));
    check({tag, " out_data"},  bus.out_data, exp_d);
    check({tag, " primed"},    24'(bus.primed), 24'(exp_p));
  endtask

  task automatic add(input logic v, input logic c, input logic [23:0] d,
                     input logic ev, input logic [23:0] ed, input logic ep);
    vec_t t;
    t.v = v; t.c = c; t.d = d; t.exp_v = ev; t.exp_d = ed; t.exp_p = ep;
    tbl.push_back(t);
  endtask

  initial begin
    int e5[10];
    e5 = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};

    // Ramp to 800, then wrap and drain with zeros.
    for (int k = 1; k <= 8; k++) add(1, 0, 24'd800, 1, 24'(100 * k), k == 8);
    add(1, 0, 24'd0, 1, 24'd700, 1);
    for (int k = 1; k <= 7; k++) add(1, 0, 24'd0, 1, 24'(700 - 100 * k), 1);
    // Floor semantics on negative means.
    add(0, 1, 24'd0, 0, 24'd0, 0);
    add(1, 0, 24'hFFFFFF, 1, 24'hFFFFFF, 0);
    add(0, 1, 24'd0, 0, 24'hFFFFFF, 0);
    add(1, 0, 24'hFFFFF7, 1, 24'hFFFFFE, 0);
    add(0, 1, 24'd0, 0, 24'hFFFFFE, 0);
    // Back-to-back strobes.
    for (int k = 0; k < 10; k++) add(1, 0, 24'(8 * (k + 1)), 1, 24'(e5[k]), k >= 7);

    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.in_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset out_valid", 24'(bus.out_valid), 24'd0);
    check("reset out_data",  bus.out_data, 24'd0);
    check("reset primed",    24'(bus.primed), 24'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      tick(tbl[i].v, tbl[i].c, tbl[i].d, tag);
      check({tag, " vec out_valid"}, 24'(bus.out_valid), 24'(tbl[i].exp_v));
      check({tag, " vec out_data"},  bus.out_data, tbl[i].exp_d);
      check({tag, " vec primed"},    24'(bus.primed), 24'(tbl[i].exp_p));
    end

    // Full-scale history reproduces the extreme value exactly.
    tick(0, 1, 24'd0, "clr");
    for (int k = 0; k < 8; k++) tick(1, 0, 24'h7FFFFF, "max");
    check("all-max mean", bus.out_data, 24'h7FFFFF);
    for (int k = 0; k < 8; k++) tick(1, 0, 24'h800000, "min");
    check("all-min mean", bus.out_data, 24'h800000);

    // Clear wins over a coincident sample.
    tick(1, 1, 24'd1000, "clr+sample");
    check("clr drop out_valid", 24'(bus.out_valid), 24'd0);
    check("clr drop primed",    24'(bus.primed), 24'd0);
    tick(1, 0, 24'd8, "after clr");
    check("after clr out_data", bus.out_data, 24'd1);

    for (int k = 0; k < 300; k++) begin
      logic v, c;
      v = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 19) == 0);
      tick(v, c, 24'($urandom), "rnd");
    end

    // Reset lands between a strobe and its output pulse.
    bus.in_valid = 1'b1;
    bus.clear    = 1'b0;
    bus.in_data  = 24'd4000;
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midrst out_valid", 24'(bus.out_valid), 24'd0);
    check("midrst out_data",  bus.out_data, 24'd0);
    check("midrst primed",    24'(bus.primed), 24'd0);
    reset_n = 1'b1;
    tick(0, 0, 24'd0, "post-rst");
    tick(0, 0, 24'd0, "post-rst");
    tick(1, 0, 24'd16, "post-rst");
    check("post-rst out_data", bus.out_data, 24'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
